// File: rtl/mux_arb_pkg.sv
// Shared constants and helpers for the two-requester round-robin mux arbiter.
package mux_arb_pkg;

  typedef logic src_t;

  localparam src_t SRC_0 = 1'b0;
  localparam src_t SRC_1 = 1'b1;

  // Width of a counter that must hold values 0..burst inclusive.
  function automatic int cnt_width(input int burst);
    return (burst < 1) ? 1 : $clog2(burst + 1);
  endfunction

endpackage

// File: rtl/mux_2to1_bus.sv
// WIDTH-bit combinational 2:1 multiplexer.
module mux_2to1_bus #(
  parameter int WIDTH = 8
) (
  input  logic [WIDTH-1:0] i_din_0,
  input  logic [WIDTH-1:0] i_din_1,
  input  logic             i_sel,
  output logic [WIDTH-1:0] o_out
);

  assign o_out = i_sel ? i_din_1 : i_din_0;

endmodule

// File: rtl/mux_arb_2to1.sv
// Two-requester bounded-burst round-robin arbiter steering a shared 2:1 mux
// into a single registered valid/ready output stage.
module mux_arb_2to1
  import mux_arb_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int BURST = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             req_0,
  input  logic [WIDTH-1:0] din_0,
  output logic             gnt_0,
  input  logic             req_1,
  input  logic [WIDTH-1:0] din_1,
  output logic             gnt_1,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] mux_out,
  output logic             out_src,
  output logic             sel
);

  localparam int            CW      = cnt_width(BURST);
  localparam logic [CW-1:0] BURST_C = CW'(BURST);
  localparam logic [CW-1:0] ONE_C   = CW'(1);

  // Handshakes: a requester's word is taken when req_x & gnt_x are high in the
  // same cycle; the output word moves when out_valid & out_ready are high.
  // gnt depends combinationally on out_ready so a draining consumer can be
  // refilled in the same cycle.

  logic             r_owner;
  logic [CW-1:0]    r_cnt;
  logic             r_out_valid;
  logic [WIDTH-1:0] r_mux_out;
  logic             r_out_src;

  logic             w_can_load;
  logic             w_prio;
  logic             w_sel;
  logic             w_gnt_0;
  logic             w_gnt_1;
  logic             w_any_gnt;
  logic [WIDTH-1:0] w_mux_d;

  // Gating with rst_n keeps grants off while reset is asserted.
  assign w_can_load = rst_n & (~r_out_valid | out_ready);
  assign w_prio     = ((r_cnt == '0) || (r_cnt == BURST_C)) ? ~r_owner : r_owner;

  always_comb begin
    w_sel = w_prio;
    if (req_0 && !req_1) begin
      w_sel = SRC_0;
    end else if (req_1 && !req_0) begin
      w_sel = SRC_1;
    end
  end

  assign w_gnt_0   = w_can_load & req_0 & (w_sel == SRC_0);
  assign w_gnt_1   = w_can_load & req_1 & (w_sel == SRC_1);
  assign w_any_gnt = w_gnt_0 | w_gnt_1;

  mux_2to1_bus #(
    .WIDTH (WIDTH)
  ) u_mux (
    .i_din_0 (din_0),
    .i_din_1 (din_1),
    .i_sel   (w_sel),
    .o_out   (w_mux_d)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_owner     <= SRC_1;
      r_cnt       <= '0;
      r_out_valid <= 1'b0;
      r_mux_out   <= '0;
      r_out_src   <= SRC_0;
    end else if (w_can_load) begin
      if (w_any_gnt) begin
        r_mux_out   <= w_mux_d;
        r_out_src   <= w_sel;
        r_out_valid <= 1'b1;
        if (w_sel == r_owner) begin
          r_cnt <= (r_cnt == BURST_C) ? BURST_C : r_cnt + ONE_C;
        end else begin
          r_owner <= w_sel;
          r_cnt   <= ONE_C;
        end
      end else begin
        // An idle loadable cycle empties the output and ends the burst.
        r_out_valid <= 1'b0;
        r_cnt       <= '0;
      end
    end
  end

  assign gnt_0     = w_gnt_0;
  assign gnt_1     = w_gnt_1;
  assign sel       = w_sel;
  assign out_valid = r_out_valid;
  assign mux_out   = r_mux_out;
  assign out_src   = r_out_src;

endmodule

// File: tb/tb_mux_arb_2to1.sv
// Directed and randomized bench for mux_arb_2to1 against a grant-history model;
// a second BURST=1 instance shares the stimulus for the alternation case.
module tb_mux_arb_2to1;

  localparam int WIDTH = 8;
  localparam int BURST = 4;

  logic             clk;
  logic             rst_n;
  logic             req_0, req_1, out_ready;
  logic [WIDTH-1:0] din_0, din_1;
  logic             gnt_0, gnt_1, out_valid, out_src, sel;
  logic [WIDTH-1:0] mux_out;
  logic             d1_gnt_0, d1_gnt_1, d1_out_valid, d1_out_src, d1_sel;
  logic [WIDTH-1:0] d1_mux_out;

  int n_pass  = 0;
  int n_total = 0;

  // Model: grant history (source index, -1 marks an idle cycle) and the
  // expected output register contents as a depth-1 queue of {src, data}.
  int               hist[$];
  logic [WIDTH:0]   exp_q[$];

  logic             cur_g0, cur_g1, cur_d1_g0, cur_d1_valid;
  logic [WIDTH-1:0] cur_mux;

  mux_arb_2to1 #(.WIDTH(WIDTH), .BURST(BURST)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_0(req_0), .din_0(din_0), .gnt_0(gnt_0),
    .req_1(req_1), .din_1(din_1), .gnt_1(gnt_1),
    .out_valid(out_valid), .out_ready(out_ready),
    .mux_out(mux_out), .out_src(out_src), .sel(sel)
  );

  mux_arb_2to1 #(.WIDTH(WIDTH), .BURST(1)) dut_b1 (
    .clk(clk), .rst_n(rst_n),
    .req_0(req_0), .din_0(din_0), .gnt_0(d1_gnt_0),
    .req_1(req_1), .din_1(din_1), .gnt_1(d1_gnt_1),
    .out_valid(d1_out_valid), .out_ready(out_ready),
    .mux_out(d1_mux_out), .out_src(d1_out_src), .sel(d1_sel)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_total++;
    assert (obs === expv) n_pass++;
    else $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, expv);
  endtask

  function automatic int last_src();
    for (int i = hist.size() - 1; i >= 0; i--) begin
      if (hist[i] >= 0) return hist[i];
    end
    return 1;
  endfunction

  function automatic int run_len();
    int l;
    int n;
    l = last_src();
    n = 0;
    for (int i = hist.size() - 1; i >= 0; i--) begin
      if (hist[i] != l) break;
      n++;
    end
    return n;
  endfunction

  function automatic void push_hist(input int v);
    if (v == -1 && hist.size() > 0 && hist[hist.size()-1] == -1) return;
    hist.push_back(v);
    if (hist.size() > 32) void'(hist.pop_front());
  endfunction

  function automatic int model_sel();
    int l;
    int r;
    int prio;
    l = last_src();
    r = run_len();
    prio = (r == 0 || r >= BURST) ? 1 - l : l;
    if (req_0 && !req_1) return 0;
    if (req_1 && !req_0) return 1;
    return prio;
  endfunction

  function automatic void model_reset();
    hist.delete();
    exp_q.delete();
  endfunction

  // One clock cycle: inputs are already driven; check at negedge, advance model at posedge.
  task automatic step();
    int   esel;
    logic can_load, eg0, eg1;
    @(negedge clk);
    can_load = (exp_q.size() == 0) || out_ready;
    esel = model_sel();
    eg0  = can_load && req_0 && (esel == 0);
    eg1  = can_load && req_1 && (esel == 1);
    chk("sel", sel, esel);
    chk("gnt_0", gnt_0, eg0);
    chk("gnt_1", gnt_1, eg1);
    chk("out_valid", out_valid, exp_q.size() != 0);
    if (exp_q.size() != 0) begin
      chk("mux_out", mux_out, exp_q[0][WIDTH-1:0]);
      chk("out_src", out_src, exp_q[0][WIDTH]);
    end
    cur_g0       = gnt_0;
    cur_g1       = gnt_1;
    cur_mux      = mux_out;
    cur_d1_g0    = d1_gnt_0;
    cur_d1_valid = d1_out_valid;
    @(posedge clk);
    if (can_load) begin
      if (exp_q.size() != 0) void'(exp_q.pop_front());
      if (eg0) begin
        exp_q.push_back({1'b0, din_0});
        push_hist(0);
      end else if (eg1) begin
        exp_q.push_back({1'b1, din_1});
        push_hist(1);
      end else begin
        push_hist(-1);
      end
    end
    #1;
  endtask

  initial begin
    rst_n = 1'b0; req_0 = 1'b1; req_1 = 1'b1; out_ready = 1'b1;
    din_0 = '0; din_1 = '0;
    model_reset();
    #1;
    chk("rst_out_valid", out_valid, 0);
    chk("rst_mux_out", mux_out, 0);
    chk("rst_out_src", out_src, 0);
    chk("rst_gnt_0", gnt_0, 0);
    chk("rst_gnt_1", gnt_1, 0);
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;

    // Contention: BURST=4 bursts of four; BURST=1 instance alternates.
    for (int i = 0; i < 12; i++) begin
      din_0 = 8'($urandom);
      din_1 = 8'($urandom);
      step();
      chk("cont_gnt_0", cur_g0, ((i / 4) % 2) == 0);
      chk("cont_gnt_1", cur_g1, ((i / 4) % 2) == 1);
      chk("b1_gnt_0", cur_d1_g0, (i % 2) == 0);
      if (i > 0) chk("b1_out_valid", cur_d1_valid, 1);
    end

    // Lone requester 1, past saturation.
    req_0 = 1'b0; req_1 = 1'b1;
    for (int i = 0; i < 10; i++) begin
      din_1 = 8'(8'h10 + i);
      step();
      chk("lone_gnt_1", cur_g1, 1);
    end

    // Backpressure holds the last word, then releases in the same cycle.
    req_1 = 1'b0; req_0 = 1'b1; din_0 = 8'hA5; out_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step();
      chk("bp_gnt_0", cur_g0, 0);
      chk("bp_mux_hold", cur_mux, 8'h19);
    end
    out_ready = 1'b1;
    step();
    chk("bp_release_gnt_0", cur_g0, 1);

    // Idle cycle ends a burst of requester 0.
    din_0 = 8'h33;
    step();
    chk("bp_new_word", cur_mux, 8'hA5);
    step();
    req_0 = 1'b0;
    step();
    req_0 = 1'b1; req_1 = 1'b1;
    step();
    chk("idle_break_gnt_1", cur_g1, 1);

    // Randomized traffic obeying the requester hold rules.
    for (int i = 0; i < 400; i++) begin
      if (cur_g0 || !req_0) begin
        req_0 = ($urandom_range(0, 3) != 0);
        din_0 = 8'($urandom);
      end
      if (cur_g1 || !req_1) begin
        req_1 = ($urandom_range(0, 3) != 0);
        din_1 = 8'($urandom);
      end
      out_ready = ($urandom_range(0, 3) != 0);
      step();
    end

    // Asynchronous reset with a word in the output register.
    req_0 = 1'b1; req_1 = 1'b1; out_ready = 1'b1;
    step();
    chk("pre_rst_valid", out_valid, 1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("mid_rst_out_valid", out_valid, 0);
    chk("mid_rst_mux_out", mux_out, 0);
    chk("mid_rst_out_src", out_src, 0);
    chk("mid_rst_gnt_0", gnt_0, 0);
    chk("mid_rst_gnt_1", gnt_1, 0);
    model_reset();
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    step();
    chk("post_rst_gnt_0", cur_g0, 1);
    step();

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
